modul_food_ctrl: RTL and testbench

- Sequences the snake game's pseudo-random position source to place food.
- On game start or food eaten, it waits a settle interval, samples random_x/random_y and asks the snake-body checker whether that cell is occupied.
- It retries on collision and, after MAX_TRIES failures, commits a fixed fallback cell.
- It sits between the random-position module, the snake body logic and the VGA draw logic.

---
 rtl/snake_pkg.sv | 24 ++
 rtl/modul_food_timer.sv | 28 ++
 rtl/modul_food_ctrl.sv | 164 ++++++++++++++++
 tb/tb_modul_food_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game food placement logic:
// coordinate widths, default fallback cell, board bounds and FSM encoding.
package snake_pkg;

   localparam int X_W     = 10;
   localparam int Y_W     = 9;
   localparam int TIMER_W = 4;
   localparam int TRIES_W = 4;

   localparam logic [X_W-1:0] FALLBACK_X_DEF = 10'd320;
   localparam logic [Y_W-1:0] FALLBACK_Y_DEF = 9'd240;

   localparam int BOARD_X_MIN = 20;
   localparam int BOARD_X_MAX = 620;
   localparam int BOARD_Y_MIN = 20;
   localparam int BOARD_Y_MAX = 460;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_QUERY
   } food_state_t;

endpackage

// File: rtl/modul_food_timer.sv
// Loadable 4-bit down-counter shared by the settle and ack-timeout phases.
// Load has priority over enable; the count holds once it reaches zero.
module modul_food_timer
   import snake_pkg::*;
(
   input  logic               VGA_clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               enable,
   output logic               zero
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/modul_food_ctrl.sv
// Food placement sequencer: waits for the random source to advance, queries the
// snake-body checker, retries on collision and falls back to a fixed cell.
module modul_food_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned      MAX_TRIES     = 8,
   parameter int unsigned      SETTLE_CYCLES = 3,
   parameter int unsigned      ACK_TIMEOUT   = 15,
   parameter logic [X_W-1:0]   FALLBACK_X    = FALLBACK_X_DEF,
   parameter logic [Y_W-1:0]   FALLBACK_Y    = FALLBACK_Y_DEF
)
(
   input  logic           VGA_clk,
   input  logic           reset,
   input  logic           game_start,
   input  logic           food_eaten,
   input  logic [X_W-1:0] random_x,
   input  logic [Y_W-1:0] random_y,
   output logic           chk_req,
   output logic [X_W-1:0] chk_x,
   output logic [Y_W-1:0] chk_y,
   input  logic           chk_ack,
   input  logic           chk_hit,
   output logic [X_W-1:0] food_x,
   output logic [Y_W-1:0] food_y,
   output logic           food_valid,
   output logic           busy,
   output logic           fallback_used,
   output logic [7:0]     placed_cnt
);

   localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] ACK_LOAD    = TIMER_W'(ACK_TIMEOUT - 1);
   localparam logic [TRIES_W-1:0] TRIES_MAX   = TRIES_W'(MAX_TRIES);

   food_state_t        state, state_d;
   logic [TRIES_W-1:0] tries, tries_d, tries_inc;
   logic               chk_req_d;
   logic [X_W-1:0]     chk_x_d, food_x_d;
   logic [Y_W-1:0]     chk_y_d, food_y_d;
   logic               food_valid_d, busy_d, fallback_d;
   logic [7:0]         placed_d;
   logic               timer_load, timer_en, timer_zero;
   logic [TIMER_W-1:0] timer_val;
   logic               start;

   modul_food_timer u_timer (
      .VGA_clk  (VGA_clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .enable   (timer_en),
      .zero     (timer_zero)
   );

   // food_eaten only counts when idle; game_start restarts from any state
   assign start     = game_start | (food_eaten & (state == ST_IDLE));
   assign tries_inc = tries + 1'b1;

   always_ff @(posedge VGA_clk or posedge reset) begin
      if (reset) begin
         state         <= ST_IDLE;
         tries         <= '0;
         chk_req       <= 1'b0;
         chk_x         <= '0;
         chk_y         <= '0;
         food_x        <= FALLBACK_X;
         food_y        <= FALLBACK_Y;
         food_valid    <= 1'b0;
         busy          <= 1'b0;
         fallback_used <= 1'b0;
         placed_cnt    <= '0;
      end else begin
         state         <= state_d;
         tries         <= tries_d;
         chk_req       <= chk_req_d;
         chk_x         <= chk_x_d;
         chk_y         <= chk_y_d;
         food_x        <= food_x_d;
         food_y        <= food_y_d;
         food_valid    <= food_valid_d;
         busy          <= busy_d;
         fallback_used <= fallback_d;
         placed_cnt    <= placed_d;
      end
   end

   always_comb begin
      state_d      = state;
      tries_d      = tries;
      chk_req_d    = chk_req;
      chk_x_d      = chk_x;
      chk_y_d      = chk_y;
      food_x_d     = food_x;
      food_y_d     = food_y;
      food_valid_d = food_valid;
      busy_d       = busy;
      fallback_d   = fallback_used;
      placed_d     = placed_cnt;
      timer_load   = 1'b0;
      timer_val    = SETTLE_LOAD;
      timer_en     = 1'b0;

      if (start) begin
         state_d      = ST_SETTLE;
         tries_d      = '0;
         chk_req_d    = 1'b0;
         food_valid_d = 1'b0;
         busy_d       = 1'b1;
         timer_load   = 1'b1;
         timer_val    = SETTLE_LOAD;
      end else begin
         case (state)
            ST_SETTLE: begin
               if (timer_zero) begin
                  chk_x_d    = random_x;
                  chk_y_d    = random_y;
                  chk_req_d  = 1'b1;
                  timer_load = 1'b1;
                  timer_val  = ACK_LOAD;
                  state_d    = ST_QUERY;
               end else begin
                  timer_en = 1'b1;
               end
            end

            ST_QUERY: begin
               if (chk_ack && !chk_hit) begin
                  chk_req_d    = 1'b0;
                  food_x_d     = chk_x;
                  food_y_d     = chk_y;
                  food_valid_d = 1'b1;
                  fallback_d   = 1'b0;
                  placed_d     = placed_cnt + 8'd1;
                  busy_d       = 1'b0;
                  state_d      = ST_IDLE;
               end else if (chk_ack || timer_zero) begin
                  // a timeout is treated exactly like an occupied cell
                  chk_req_d = 1'b0;
                  tries_d   = tries_inc;
                  if (tries_inc == TRIES_MAX) begin
                     food_x_d     = FALLBACK_X;
                     food_y_d     = FALLBACK_Y;
                     food_valid_d = 1'b1;
                     fallback_d   = 1'b1;
                     placed_d     = placed_cnt + 8'd1;
                     busy_d       = 1'b0;
                     state_d      = ST_IDLE;
                  end else begin
                     timer_load = 1'b1;
                     timer_val  = SETTLE_LOAD;
                     state_d    = ST_SETTLE;
                  end
               end else begin
                  timer_en = 1'b1;
               end
            end

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_modul_food_ctrl.sv
// Directed bench for modul_food_ctrl; the bench plays the random source and
// the snake-body checker with hand-computed expectations.
module tb_modul_food_ctrl;

   logic       VGA_clk = 1'b0;
   logic       reset, game_start, food_eaten, chk_ack, chk_hit;
   logic [9:0] random_x, chk_x, food_x;
   logic [8:0] random_y, chk_y, food_y;
   logic       chk_req, food_valid, busy, fallback_used;
   logic [7:0] placed_cnt;

   int checks   = 0;
   int failures = 0;

   modul_food_ctrl dut (
      .VGA_clk       (VGA_clk),
      .reset         (reset),
      .game_start    (game_start),
      .food_eaten    (food_eaten),
      .random_x      (random_x),
      .random_y      (random_y),
      .chk_req       (chk_req),
      .chk_x         (chk_x),
      .chk_y         (chk_y),
      .chk_ack       (chk_ack),
      .chk_hit       (chk_hit),
      .food_x        (food_x),
      .food_y        (food_y),
      .food_valid    (food_valid),
      .busy          (busy),
      .fallback_used (fallback_used),
      .placed_cnt    (placed_cnt)
   );

   always #5 VGA_clk = ~VGA_clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advances negedge by negedge, releasing one-cycle pulses, until chk_req is seen.
   task automatic wait_req(output int lows, output bit ok);
      lows = 0;
      ok   = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge VGA_clk);
         game_start = 1'b0;
         food_eaten = 1'b0;
         chk_ack    = 1'b0;
         if (chk_req === 1'b1) begin
            ok = 1'b1;
            break;
         end
         lows++;
      end
   endtask

   task automatic test_reset();
      int lows;
      bit ok;
      reset = 1'b1; game_start = 1'b0; food_eaten = 1'b0;
      chk_ack = 1'b0; chk_hit = 1'b0; random_x = '0; random_y = '0;
      repeat (3) @(negedge VGA_clk);
      checks++; if (food_x !== 10'd320) begin failures++; $display("[TB] FAIL rst_food_x: got=%0d exp=320", food_x); end
      checks++; if (food_y !== 9'd240) begin failures++; $display("[TB] FAIL rst_food_y: got=%0d exp=240", food_y); end
      checks++; if ({food_valid, busy, chk_req, fallback_used} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_flags: got=%b exp=0000", {food_valid, busy, chk_req, fallback_used}); end
      checks++; if (placed_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rst_placed: got=%0d exp=0", placed_cnt); end
      reset = 1'b0;
      @(negedge VGA_clk);
      random_x = 10'd100; random_y = 9'd50; game_start = 1'b1;
      wait_req(lows, ok);
      checks++; if (!ok || chk_x !== 10'd100) begin failures++; $display("[TB] FAIL pre_rst_query: got=%0d exp=100", chk_x); end
      #2 reset = 1'b1;
      #1;
      checks++; if (chk_req !== 1'b0) begin failures++; $display("[TB] FAIL async_rst_req: got=%b exp=0", chk_req); end
      checks++; if (chk_x !== 10'd0 || chk_y !== 9'd0) begin failures++; $display("[TB] FAIL async_rst_chk: got=%0d,%0d exp=0,0", chk_x, chk_y); end
      checks++; if (food_x !== 10'd320 || food_y !== 9'd240) begin failures++; $display("[TB] FAIL async_rst_food: got=%0d,%0d exp=320,240", food_x, food_y); end
      checks++; if (food_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL async_rst_flags: got=%b%b exp=00", food_valid, busy); end
      @(negedge VGA_clk);
      reset = 1'b0;
   endtask

   task automatic test_first_placement();
      @(negedge VGA_clk);
      random_x = 10'd189; random_y = 9'd99; game_start = 1'b1;
      @(negedge VGA_clk);
      game_start = 1'b0;
      checks++; if (busy !== 1'b1 || chk_req !== 1'b0) begin failures++; $display("[TB] FAIL first_n0: got busy=%b req=%b exp busy=1 req=0", busy, chk_req); end
      for (int i = 1; i < 3; i++) begin
         @(negedge VGA_clk);
         checks++; if (chk_req !== 1'b0) begin failures++; $display("[TB] FAIL first_settle%0d: got=%b exp=0", i, chk_req); end
      end
      @(negedge VGA_clk);
      checks++; if (chk_req !== 1'b1) begin failures++; $display("[TB] FAIL first_req_n3: got=%b exp=1", chk_req); end
      checks++; if (chk_x !== 10'd189 || chk_y !== 9'd99) begin failures++; $display("[TB] FAIL first_chk_xy: got=%0d,%0d exp=189,99", chk_x, chk_y); end
      chk_ack = 1'b1; chk_hit = 1'b0;
      @(negedge VGA_clk);
      chk_ack = 1'b0;
      checks++; if (food_x !== 10'd189 || food_y !== 9'd99) begin failures++; $display("[TB] FAIL first_food: got=%0d,%0d exp=189,99", food_x, food_y); end
      checks++; if (food_valid !== 1'b1 || busy !== 1'b0 || chk_req !== 1'b0) begin failures++; $display("[TB] FAIL first_flags: got valid=%b busy=%b req=%b exp 1,0,0", food_valid, busy, chk_req); end
      checks++; if (placed_cnt !== 8'd1) begin failures++; $display("[TB] FAIL first_placed: got=%0d exp=1", placed_cnt); end
   endtask

   task automatic test_retries();
      logic [9:0] cx [3];
      logic [8:0] cy [3];
      int lows;
      bit ok;
      cx[0] = 10'd40; cx[1] = 10'd300; cx[2] = 10'd600;
      cy[0] = 9'd30;  cy[1] = 9'd200;  cy[2] = 9'd450;
      @(negedge VGA_clk);
      random_x = cx[0]; random_y = cy[0]; food_eaten = 1'b1;
      for (int e = 0; e < 3; e++) begin
         wait_req(lows, ok);
         checks++; if (!ok || lows != 3) begin failures++; $display("[TB] FAIL retry_settle%0d: got ok=%0d lows=%0d exp ok=1 lows=3", e, ok, lows); end
         checks++; if (chk_x !== cx[e] || chk_y !== cy[e]) begin failures++; $display("[TB] FAIL retry_chk%0d: got=%0d,%0d exp=%0d,%0d", e, chk_x, chk_y, cx[e], cy[e]); end
         checks++; if (food_x !== 10'd189) begin failures++; $display("[TB] FAIL retry_food_frozen%0d: got=%0d exp=189", e, food_x); end
         chk_ack = 1'b1; chk_hit = (e < 2);
         if (e < 2) begin
            random_x = cx[e+1]; random_y = cy[e+1];
         end
      end
      @(negedge VGA_clk);
      chk_ack = 1'b0;
      checks++; if (food_x !== 10'd600 || food_y !== 9'd450) begin failures++; $display("[TB] FAIL retry_food: got=%0d,%0d exp=600,450", food_x, food_y); end
      checks++; if (fallback_used !== 1'b0 || food_valid !== 1'b1) begin failures++; $display("[TB] FAIL retry_flags: got fb=%b valid=%b exp 0,1", fallback_used, food_valid); end
      checks++; if (placed_cnt !== 8'd2) begin failures++; $display("[TB] FAIL retry_placed: got=%0d exp=2", placed_cnt); end
   endtask

   task automatic test_fallback_hits();
      int lows;
      int queries = 0;
      bit ok;
      @(negedge VGA_clk);
      random_x = 10'd77; random_y = 9'd66; food_eaten = 1'b1;
      for (int a = 0; a < 8; a++) begin
         wait_req(lows, ok);
         if (ok) queries++;
         chk_ack = 1'b1; chk_hit = 1'b1;
      end
      @(negedge VGA_clk);
      chk_ack = 1'b0;
      checks++; if (queries != 8) begin failures++; $display("[TB] FAIL hits_queries: got=%0d exp=8", queries); end
      checks++; if (food_x !== 10'd320 || food_y !== 9'd240) begin failures++; $display("[TB] FAIL hits_food: got=%0d,%0d exp=320,240", food_x, food_y); end
      checks++; if (fallback_used !== 1'b1 || food_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL hits_flags: got fb=%b valid=%b busy=%b exp 1,1,0", fallback_used, food_valid, busy); end
      checks++; if (placed_cnt !== 8'd3) begin failures++; $display("[TB] FAIL hits_placed: got=%0d exp=3", placed_cnt); end
      repeat (4) @(negedge VGA_clk);
      checks++; if (chk_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL hits_quiet: got req=%b busy=%b exp 0,0", chk_req, busy); end
   endtask

   task automatic test_simultaneous();
      int lows;
      bit ok;
      @(negedge VGA_clk);
      random_x = 10'd500; random_y = 9'd400; game_start = 1'b1; food_eaten = 1'b1;
      wait_req(lows, ok);
      checks++; if (!ok || lows != 3) begin failures++; $display("[TB] FAIL simul_settle: got ok=%0d lows=%0d exp ok=1 lows=3", ok, lows); end
      chk_ack = 1'b1; chk_hit = 1'b0;
      @(negedge VGA_clk);
      chk_ack = 1'b0;
      checks++; if (food_x !== 10'd500 || food_y !== 9'd400 || fallback_used !== 1'b0) begin failures++; $display("[TB] FAIL simul_food: got=%0d,%0d fb=%b exp=500,400 fb=0", food_x, food_y, fallback_used); end
      repeat (6) @(negedge VGA_clk);
      checks++; if (placed_cnt !== 8'd4 || busy !== 1'b0 || chk_req !== 1'b0) begin failures++; $display("[TB] FAIL simul_single: got placed=%0d busy=%b req=%b exp 4,0,0", placed_cnt, busy, chk_req); end
   endtask

   task automatic test_timeout();
      int lows, highs;
      bit ok;
      @(negedge VGA_clk);
      random_x = 10'd250; random_y = 9'd150; game_start = 1'b1;
      @(negedge VGA_clk);
      game_start = 1'b0;
      checks++; if (food_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL tmo_start: got valid=%b busy=%b exp 0,1", food_valid, busy); end
      for (int a = 0; a < 8; a++) begin
         wait_req(lows, ok);
         checks++; if (!ok || lows != 2) begin failures++; $display("[TB] FAIL tmo_settle%0d: got ok=%0d lows=%0d exp ok=1 lows=2", a, ok, lows); end
         checks++; if (food_x !== 10'd500) begin failures++; $display("[TB] FAIL tmo_food_frozen%0d: got=%0d exp=500", a, food_x); end
         highs = 1;
         for (int i = 0; i < 40; i++) begin
            @(negedge VGA_clk);
            if (chk_req !== 1'b1) break;
            highs++;
         end
         checks++; if (highs != 15) begin failures++; $display("[TB] FAIL tmo_req_len%0d: got=%0d exp=15", a, highs); end
      end
      checks++; if (food_x !== 10'd320 || food_y !== 9'd240 || fallback_used !== 1'b1) begin failures++; $display("[TB] FAIL tmo_food: got=%0d,%0d fb=%b exp=320,240 fb=1", food_x, food_y, fallback_used); end
      checks++; if (placed_cnt !== 8'd5 || food_valid !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL tmo_commit: got placed=%0d valid=%b busy=%b exp 5,1,0", placed_cnt, food_valid, busy); end
   endtask

   task automatic test_restart_in_query();
      int lows;
      int found = 0;
      bit ok;
      @(negedge VGA_clk);
      random_x = 10'd111; random_y = 9'd222; food_eaten = 1'b1;
      wait_req(lows, ok);
      chk_ack = 1'b1; chk_hit = 1'b1;
      wait_req(lows, ok);
      checks++; if (!ok || lows != 3) begin failures++; $display("[TB] FAIL rs_second_query: got ok=%0d lows=%0d exp ok=1 lows=3", ok, lows); end
      game_start = 1'b1;
      @(negedge VGA_clk);
      game_start = 1'b0;
      checks++; if (chk_req !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL rs_drop: got req=%b busy=%b exp 0,1", chk_req, busy); end
      wait_req(lows, ok);
      checks++; if (!ok || lows != 2) begin failures++; $display("[TB] FAIL rs_settle: got ok=%0d lows=%0d exp ok=1 lows=2", ok, lows); end
      for (int a = 0; a < 7; a++) begin
         chk_ack = 1'b1; chk_hit = 1'b1;
         wait_req(lows, ok);
         if (ok) found++;
      end
      checks++; if (found != 7) begin failures++; $display("[TB] FAIL rs_tries_cleared: got=%0d exp=7", found); end
      chk_ack = 1'b1; chk_hit = 1'b0;
      @(negedge VGA_clk);
      chk_ack = 1'b0;
      checks++; if (food_x !== 10'd111 || food_y !== 9'd222 || fallback_used !== 1'b0) begin failures++; $display("[TB] FAIL rs_food: got=%0d,%0d fb=%b exp=111,222 fb=0", food_x, food_y, fallback_used); end
      checks++; if (placed_cnt !== 8'd6) begin failures++; $display("[TB] FAIL rs_placed: got=%0d exp=6", placed_cnt); end
   endtask

   initial begin
      test_reset();
      test_first_placement();
      test_retries();
      test_fallback_hits();
      test_simultaneous();
      test_timeout();
      test_restart_in_query();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
